// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle between the core-side masters, the arbiter and the memory bus.
// The arbiter connects through the slave modport; the cores and memory use the master modport.
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [NUM_MASTERS-1:0]            m_cyc;
    logic [NUM_MASTERS-1:0]            m_stb;
    logic [NUM_MASTERS-1:0]            m_we;
    logic [NUM_MASTERS*STRB_W-1:0]     m_wstrb;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
    logic [DATA_WIDTH-1:0]             m_rdata;
    logic [NUM_MASTERS-1:0]            m_ack;
    logic [NUM_MASTERS-1:0]            m_err;

    logic                              s_cyc;
    logic                              s_stb;
    logic                              s_we;
    logic [STRB_W-1:0]                 s_wstrb;
    logic [ADDR_WIDTH-1:0]             s_addr;
    logic [DATA_WIDTH-1:0]             s_wdata;
    logic [DATA_WIDTH-1:0]             s_rdata;
    logic                              s_ack;

    modport slave (
        input  m_cyc, m_stb, m_we, m_wstrb, m_addr, m_wdata,
        output m_rdata, m_ack, m_err,
        output s_cyc, s_stb, s_we, s_wstrb, s_addr, s_wdata,
        input  s_rdata, s_ack
    );

    modport master (
        output m_cyc, m_stb, m_we, m_wstrb, m_addr, m_wdata,
        input  m_rdata, m_ack, m_err,
        input  s_cyc, s_stb, s_we, s_wstrb, s_addr, s_wdata,
        output s_rdata, s_ack
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone-classic arbiter merging NUM_MASTERS masters onto one memory bus.
// Define ARB_TIMEOUT_EN to add the BUSY watchdog that ends a stuck cycle with an m_err pulse.
//
// state   | meaning
// IDLE    | waiting for any request, picks next winner round-robin
// BUSY    | slave cycle open for the granted master
// RELEASE | one dead cycle that retires ack/err and ignores stale strobes
module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int GW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    wb_rr_arbiter_if.slave        bus,
    output logic [GW-1:0]         grant,
    output logic                  busy
);
    localparam int STRB_W = DATA_WIDTH / 8;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2)
    begin : g_param_check
        $error("wb_rr_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

    state_t                 state;
    logic [GW-1:0]          last;
    logic [GW-1:0]          winner;
    logic [GW-1:0]          cand;
    logic                   found;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant_hot;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmr;
`endif

    always_comb begin
        req       = bus.m_cyc & bus.m_stb;
        grant_hot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << grant;
    end

    // Search starts one past the last winner so every requester is served in turn.
    always_comb begin
        winner = last;
        cand   = last;
        found  = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = GW'((int'(last) + k) % NUM_MASTERS);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= GW'(NUM_MASTERS - 1);
            grant       <= '0;
            busy        <= 1'b0;
            bus.s_cyc   <= 1'b0;
            bus.s_stb   <= 1'b0;
            bus.s_we    <= 1'b0;
            bus.s_wstrb <= '0;
            bus.s_addr  <= '0;
            bus.s_wdata <= '0;
            bus.m_ack   <= '0;
            bus.m_err   <= '0;
            bus.m_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
            tmr         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        bus.s_we    <= bus.m_we[winner];
                        bus.s_wstrb <= bus.m_wstrb[winner*STRB_W +: STRB_W];
                        bus.s_addr  <= bus.m_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                        bus.s_wdata <= bus.m_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
                        bus.s_cyc   <= 1'b1;
                        bus.s_stb   <= 1'b1;
                        grant       <= winner;
                        last        <= winner;
                        busy        <= 1'b1;
                        state       <= BUSY;
`ifdef ARB_TIMEOUT_EN
                        tmr         <= TW'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
                BUSY: begin
                    // Abort outranks a simultaneous ack: the master has already left.
                    if (!bus.m_cyc[grant]) begin
                        bus.s_cyc <= 1'b0;
                        bus.s_stb <= 1'b0;
                        busy      <= 1'b0;
                        state     <= RELEASE;
                    end else if (bus.s_ack) begin
                        bus.s_cyc   <= 1'b0;
                        bus.s_stb   <= 1'b0;
                        bus.m_ack   <= grant_hot;
                        bus.m_rdata <= bus.s_rdata;
                        busy        <= 1'b0;
                        state       <= RELEASE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmr == '0) begin
                        bus.s_cyc <= 1'b0;
                        bus.s_stb <= 1'b0;
                        bus.m_err <= grant_hot;
                        busy      <= 1'b0;
                        state     <= RELEASE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
`endif
                end
                RELEASE: begin
                    bus.m_ack <= '0;
                    bus.m_err <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter: directed master/slave traffic, expected grants and
// responses queued by the stimulus and checked by an independent monitor.
module tb_wb_rr_arbiter;
    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant;
    logic       busy;

    always #5 sys_clk = ~sys_clk;

    wb_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    wb_rr_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .grant   (grant),
        .busy    (busy)
    );

    typedef struct {
        int          m;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        int          m;
        int          kind;   // 0 ack, 1 err
        logic [31:0] rdata;
    } resp_t;

    grant_t gq[$];
    resp_t  rq[$];

    int          checks = 0;
    int          errors = 0;
    int          tmode = 0;
    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    logic        rd_fixed_en = 1'b0;
    logic [31:0] rd_fixed = 32'h0;
    logic        check_period = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0d", name, act);
    endtask

    function automatic logic [31:0] addr_of(int i, int n);
        if (tmode == 1) return 32'h0000_0100;
        return 32'(32'h1000 * (i + 1) + n * 4);
    endfunction

    function automatic logic [31:0] data_of(int i, int n);
        if (tmode == 1) return 32'hDEAD_BEEF;
        return 32'(32'hA500_0000 + i * 256 + n);
    endfunction

    function automatic logic [3:0] wstrb_of(int i, int n);
        if (tmode == 1) return 4'b0011;
        return 4'(i * 3 + n + 1);
    endfunction

    function automatic logic we_of(int i, int n);
        if (tmode == 1) return 1'b1;
        if (tmode == 4) return 1'b0;
        return ((i + n) % 2) == 0;
    endfunction

    // kind < 0: a grant is expected but no response (abort or reset).
    task automatic push_txn(input int m, input int n, input int kind);
        grant_t g;
        resp_t  r;
        g.m     = m;
        g.we    = we_of(m, n);
        g.wstrb = wstrb_of(m, n);
        g.addr  = addr_of(m, n);
        g.wdata = data_of(m, n);
        gq.push_back(g);
        if (kind >= 0) begin
            r.m     = m;
            r.kind  = kind;
            r.rdata = rd_fixed_en ? rd_fixed : ~addr_of(m, n);
            rq.push_back(r);
        end
    endtask

    task automatic drive_master(input int i, input int n, input logic on);
        bus.m_cyc[i] = on;
        bus.m_stb[i] = on;
        if (on) begin
            bus.m_we[i]                = we_of(i, n);
            bus.m_wstrb[i*SW +: SW]    = wstrb_of(i, n);
            bus.m_addr[i*AW +: AW]     = addr_of(i, n);
            bus.m_wdata[i*DW +: DW]    = data_of(i, n);
        end
    endtask

    task automatic queues_empty();
        repeat (3) @(negedge sys_clk);
        chk("grant_queue_drained", 32'(gq.size()), 32'd0);
        chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    endtask

    task automatic run_masters(input int c0, input int c1, input int c2);
        int rem[NM];
        int nidx[NM];
        int budget;
        rem  = '{c0, c1, c2};
        nidx = '{0, 0, 0};
        for (budget = 0; budget < 400; budget++) begin
            @(negedge sys_clk);
            for (int i = 0; i < NM; i++)
                if (bus.m_ack[i] || bus.m_err[i]) begin
                    rem[i]--;
                    nidx[i]++;
                end
            for (int i = 0; i < NM; i++) drive_master(i, nidx[i], rem[i] > 0);
            if (rem[0] <= 0 && rem[1] <= 0 && rem[2] <= 0) break;
        end
        if (budget >= 400) fail("run_budget", budget);
        queues_empty();
    endtask

    task automatic wait_stb();
        int w;
        w = 0;
        while (!bus.s_stb && w < 20) begin
            @(negedge sys_clk);
            w++;
        end
        if (w >= 20) fail("wait_stb_budget", w);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    // Slave model: acks in BUSY cycle ack_delay+1, returns ~addr or a fixed word.
    initial begin : slave
        int cnt;
        cnt         = 0;
        bus.s_ack   = 1'b0;
        bus.s_rdata = '0;
        forever begin
            @(negedge sys_clk);
            if (bus.s_cyc === 1'b1 && bus.s_stb === 1'b1) begin
                cnt++;
                bus.s_ack   = ack_en && (cnt == ack_delay + 1);
                bus.s_rdata = rd_fixed_en ? rd_fixed : ~bus.s_addr;
            end else begin
                cnt       = 0;
                bus.s_ack = 1'b0;
            end
        end
    end

    initial begin : monitor
        grant_t cur;
        resp_t  r;
        logic   prev_stb;
        logic   prev_pulse;
        logic   rise_in_window;
        int     busy_len;
        int     cyc_no;
        int     last_rise;
        prev_stb       = 1'b0;
        prev_pulse     = 1'b0;
        rise_in_window = 1'b0;
        busy_len       = 0;
        cyc_no         = 0;
        last_rise      = 0;
        cur            = '{0, 1'b0, 4'h0, 32'h0, 32'h0};
        forever begin
            @(negedge sys_clk);
            cyc_no++;
            if (bus.s_stb === 1'b1 && !prev_stb) begin
                if (gq.size() == 0) begin
                    fail("unexpected_grant", int'(grant));
                end else begin
                    cur = gq.pop_front();
                    chk("grant", 32'(grant), 32'(cur.m));
                    chk("s_we", 32'(bus.s_we), 32'(cur.we));
                    chk("s_wstrb", 32'(bus.s_wstrb), 32'(cur.wstrb));
                    chk("s_addr", bus.s_addr, cur.addr);
                    chk("s_wdata", bus.s_wdata, cur.wdata);
                    chk("s_cyc_on_grant", 32'(bus.s_cyc), 32'd1);
                    chk("busy_on_grant", 32'(busy), 32'd1);
                    if (check_period && rise_in_window)
                        chk("period", 32'(cyc_no - last_rise), 32'd3);
                end
                last_rise      = cyc_no;
                rise_in_window = check_period;
                busy_len       = 1;
            end else if (bus.s_stb === 1'b1) begin
                busy_len++;
                chk("stable_addr", bus.s_addr, cur.addr);
                chk("stable_wdata", bus.s_wdata, cur.wdata);
                chk("stable_wstrb", 32'(bus.s_wstrb), 32'(cur.wstrb));
                chk("stable_we", 32'(bus.s_we), 32'(cur.we));
            end
            if ((|bus.m_ack) || (|bus.m_err)) begin
                chk("pulse_single_cycle", 32'(prev_pulse), 32'd0);
                if (rq.size() == 0) begin
                    fail("unexpected_response", int'({bus.m_err, bus.m_ack}));
                end else begin
                    r = rq.pop_front();
                    if (r.kind == 0) begin
                        chk("ack_onehot", 32'(bus.m_ack), 32'(1 << r.m));
                        chk("err_with_ack", 32'(bus.m_err), 32'd0);
                        chk("rdata", bus.m_rdata, r.rdata);
                        chk("ack_latency", 32'(busy_len), 32'(ack_delay + 1));
                    end else begin
                        chk("err_onehot", 32'(bus.m_err), 32'(1 << r.m));
                        chk("ack_with_err", 32'(bus.m_ack), 32'd0);
                        chk("timeout_len", 32'(busy_len), 32'(TO));
                    end
                end
            end
            prev_stb   = (bus.s_stb === 1'b1);
            prev_pulse = (|bus.m_ack) || (|bus.m_err);
        end
    end

    initial begin : stim
        rst_n       = 1'b0;
        bus.m_cyc   = '0;
        bus.m_stb   = '0;
        bus.m_we    = '0;
        bus.m_wstrb = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        repeat (3) @(negedge sys_clk);

        chk("rst_s_cyc", 32'(bus.s_cyc), 32'd0);
        chk("rst_s_stb", 32'(bus.s_stb), 32'd0);
        chk("rst_s_we", 32'(bus.s_we), 32'd0);
        chk("rst_s_wstrb", 32'(bus.s_wstrb), 32'd0);
        chk("rst_s_addr", bus.s_addr, 32'd0);
        chk("rst_s_wdata", bus.s_wdata, 32'd0);
        chk("rst_m_ack", 32'(bus.m_ack), 32'd0);
        chk("rst_m_err", 32'(bus.m_err), 32'd0);
        chk("rst_m_rdata", bus.m_rdata, 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // single write, slave acks in the third BUSY cycle
        tmode = 1; ack_delay = 2;
        push_txn(0, 0, 0);
        run_masters(1, 0, 0);

        // two continuous requesters, zero-wait slave: 0,1,0,1,0,1 every 3 cycles
        do_reset();
        tmode = 2; ack_delay = 0; check_period = 1'b1;
        push_txn(0, 0, 0); push_txn(1, 0, 0);
        push_txn(0, 1, 0); push_txn(1, 1, 0);
        push_txn(0, 2, 0); push_txn(1, 2, 0);
        run_masters(3, 3, 0);
        check_period = 1'b0;

        // masters 1 and 2 only: 1,2,1
        do_reset();
        tmode = 3; ack_delay = 1;
        push_txn(1, 0, 0); push_txn(2, 0, 0); push_txn(1, 1, 0);
        run_masters(0, 2, 1);

        // reads returning a fixed word, zero-wait
        tmode = 4; ack_delay = 0; rd_fixed_en = 1'b1; rd_fixed = 32'h1234_5678; check_period = 1'b1;
        push_txn(1, 0, 0); push_txn(1, 1, 0);
        run_masters(0, 2, 0);
        check_period = 1'b0; rd_fixed_en = 1'b0;

        // abort in the 2nd BUSY cycle, colliding with the slave ack
        tmode = 5; ack_delay = 1;
        push_txn(0, 0, -1);
        @(negedge sys_clk);
        drive_master(0, 0, 1'b1);
        wait_stb();
        @(negedge sys_clk);
        drive_master(0, 0, 1'b0);
        @(negedge sys_clk);
        chk("abort_s_cyc", 32'(bus.s_cyc), 32'd0);
        chk("abort_s_stb", 32'(bus.s_stb), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_ack", 32'(bus.m_ack), 32'd0);
        queues_empty();

        // reset while BUSY
        tmode = 6; ack_en = 1'b0;
        push_txn(2, 0, -1);
        @(negedge sys_clk);
        drive_master(2, 0, 1'b1);
        wait_stb();
        @(negedge sys_clk);
        rst_n = 1'b0;
        drive_master(2, 0, 1'b0);
        @(negedge sys_clk);
        chk("rst_busy_s_cyc", 32'(bus.s_cyc), 32'd0);
        chk("rst_busy_no_ack", 32'(bus.m_ack), 32'd0);
        chk("rst_busy_busy", 32'(busy), 32'd0);
        chk("rst_busy_grant", 32'(grant), 32'd0);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        queues_empty();

`ifdef ARB_TIMEOUT_EN
        // slave never acks -> err after TO BUSY cycles; then ack exactly in the last cycle
        do_reset();
        tmode = 7; ack_en = 1'b0;
        push_txn(0, 0, 1);
        run_masters(1, 0, 0);
        ack_en = 1'b1; ack_delay = TO - 1;
        push_txn(0, 0, 0);
        run_masters(1, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised Wishbone-classic arbiter that merges NUM_MASTERS core-side master ports (instruction fetch, data, debug, …) onto the single memory bus exported to the Controller. It generalises the fixed single-bus / optional-second-memory hookup in processorci_top. It adds fair round-robin arbitration, real per-master byte strobes in place of a constant all-ones strobe, transaction abort, and an optional bus-timeout watchdog. It sits between the core's bus ports and the core_* bus of the top level.

## Interface
- NUM_MASTERS, 2, number of master ports (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8); STRB_W = DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
- sys_clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- m_cyc_i / m_stb_i / m_we_i  in  NUM_MASTERS each  per-master cycle, strobe, write
- m_wstrb_i  in  NUM_MASTERS*STRB_W  per-master byte strobes, master i at slice i
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  per-master address
- m_data_i  in  NUM_MASTERS*DATA_WIDTH  per-master write data
- m_data_o  out  DATA_WIDTH  read data, shared by all masters, valid with m_ack_o
- m_ack_o  out  NUM_MASTERS  one-hot ack pulse
- m_err_o  out  NUM_MASTERS  one-hot timeout-error pulse
- s_cyc_o / s_stb_o / s_we_o  out  1 each  slave bus controls
- s_wstrb_o  out  STRB_W  slave byte strobes
- s_addr_o  out  ADDR_WIDTH  slave address
- s_data_o  out  DATA_WIDTH  slave write data
- s_data_i  in  DATA_WIDTH  slave read data
- s_ack_i  in  1  slave ack
- grant_o  out  $clog2(NUM_MASTERS) (min 1)  index of current or last granted master
- busy_o  out  1  high in BUSY

## Operation
- Request from master i: m_cyc_i[i] & m_stb_i[i].
- FSM states: IDLE, BUSY, RELEASE.
- IDLE, any request present:
  - Winner is the first requester searched cyclically from (last+1) mod NUM_MASTERS.
  - Latch the winner's we/wstrb/addr/data into the s_* registers.
  - Set s_cyc_o = s_stb_o = 1, grant_o = winner, last = winner, go to BUSY.
- BUSY, s_ack_i = 1:
  - Clear s_cyc_o and s_stb_o.
  - m_ack_o[grant] = 1, m_data_o = s_data_i (captured for reads and writes).
  - Go to RELEASE.
- BUSY, m_cyc_i[grant] = 0 (abort): clear s_cyc_o and s_stb_o, no ack, go to RELEASE. If abort and s_ack_i occur in the same cycle, abort wins and no ack is issued.
- RELEASE: clear m_ack_o and m_err_o, go to IDLE. Requests are ignored in this cycle, so a master's stale stb is never resampled.
- Requests from non-granted masters are held off with no ack; they stay pending.
- Reset: every output is 0, state IDLE, last = NUM_MASTERS-1 so master 0 wins first. Reset mid-transaction drops s_cyc_o immediately at that edge and issues no ack.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Request sampled at edge k gives s_stb_o high from edge k.
- s_ack_i high at edge j gives m_ack_o high and s_stb_o low for the cycle after edge j. Next grant is possible at edge j+2.
- Zero-wait-state slave (ack in the first BUSY cycle): 3 cycles per transaction.
- m_ack_o and m_err_o are exactly one-cycle pulses, at most one bit set, never both.
- s_* address, data, we and wstrb stay stable for the whole BUSY period.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A cycle counter runs in BUSY; it is cleared on entry to BUSY.
  - If the counter reaches TIMEOUT_CYCLES-1 with no s_ack_i, clear s_cyc_o/s_stb_o, pulse m_err_o[grant], go to RELEASE.
  - s_ack_i in the timeout cycle wins: a normal ack is issued, no err.
- ARB_TIMEOUT_EN undefined: no counter, m_err_o is constant 0, BUSY waits indefinitely.

## Test plan
- Single master 0 write, addr 0x100, data 0xDEADBEEF, wstrb 0b0011, slave acks after 2 cycles -> s_wstrb_o = 0b0011 and data stable throughout; m_ack_o = 0b01 for exactly one cycle.
- Masters 0 and 1 request continuously, 6 transactions -> grant_o sequence 0,1,0,1,0,1; no back-to-back grants to the same master.
- NUM_MASTERS = 3, only masters 1 and 2 requesting -> grants alternate 1,2,1; master 0 never acked.
- Read with s_data_i = 0x12345678 -> m_data_o = 0x12345678 in the m_ack_o cycle; zero-wait slave gives a 3-cycle period.
- Master drops m_cyc_i in the 2nd BUSY cycle; separately, rst_n low mid-BUSY -> s_cyc_o low next edge, no m_ack_o pulse in either case.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never acks -> m_err_o[grant] pulses after 8 BUSY cycles; with ack in cycle 8 -> m_ack_o pulses, m_err_o stays 0.
